// File: rtl/wb_write_sequencer.sv
// Write-back front end for the Y86-64 SEQ core: serialises a dstE/dstM request
// onto the single register-file write port, E before M, then pulses wb_done.
module wb_write_sequencer #(
  parameter int         DATA_W = 64,
  parameter logic [3:0] RNONE  = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [3:0]        dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic [3:0]        dstM,
  input  logic [DATA_W-1:0] valM,
  output logic              rf_write,
  output logic [3:0]        rf_dst,
  output logic [DATA_W-1:0] rf_data,
  output logic              wb_done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, WR_E, WR_M, NOP} state_t;

  typedef struct packed {
    logic [3:0]        dst_e;
    logic [DATA_W-1:0] val_e;
    logic [3:0]        dst_m;
    logic [DATA_W-1:0] val_m;
  } req_t;

  state_t            state_q, state_d;
  req_t              req_q, req_d, req_in;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;
  logic              err_q, err_d;
  logic              accept;

  assign req_in   = '{dst_e: dstE, val_e: valE, dst_m: dstM, val_m: valM};
  assign wb_ready = (state_q == IDLE) && !rst;
  assign accept   = wb_valid && wb_ready;
  assign err      = err_q;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    err_d     = err_q;
    rf_write  = 1'b0;
    rf_dst    = RNONE;
    rf_data   = rf_data_q;
    wb_done   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          req_d = req_in;
          // dstE == dstM collapses to the single M write (popq %rsp rule)
          if (dstE != RNONE && dstE != dstM) state_d = WR_E;
          else if (dstM != RNONE)            state_d = WR_M;
          else                               state_d = NOP;
        end
      end
      WR_E: begin
        rf_write = 1'b1;
        rf_dst   = req_q.dst_e;
        rf_data  = req_q.val_e;
        if (req_q.dst_m != RNONE) begin
          state_d = WR_M;
        end else begin
          wb_done = 1'b1;
          state_d = IDLE;
        end
      end
      WR_M: begin
        rf_write = 1'b1;
        rf_dst   = req_q.dst_m;
        rf_data  = req_q.val_m;
        wb_done  = 1'b1;
        state_d  = IDLE;
      end
      NOP: begin
        wb_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // producer altered a request it is still holding while we are busy
    if (wb_valid && !wb_ready && (req_in != req_q)) err_d = 1'b1;

    rf_data_d = rf_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= '{dst_e: RNONE, val_e: '0, dst_m: RNONE, val_m: '0};
      rf_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      rf_data_q <= rf_data_d;
      err_q     <= err_d;
    end
  end

endmodule
